pipe_stage_hs: RTL and testbench

Parametrised pipeline stage register with valid/ready handshake, synchronous flush, optional skid entry and a saturating back-pressure counter. Generalises the fixed-field, always-advancing inter-stage registers to any payload width with real flow control. Used between core pipeline stages (e.g. MEM→WB) and anywhere a downstream consumer can stall. Payload fields are concatenated by the instantiating stage into `in_data`.

---
 rtl/pipe_stage_hs.sv | 108 ++++++++++
 tb/tb_pipe_stage_hs.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with valid/ready handshake, synchronous flush, optional skid entry
// and a saturating back-pressure counter.
module pipe_stage_hs #(
  parameter int unsigned DATA_W = 71,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  localparam bit UseSkid = (SKID != 0);

  // Bit 0 is the main-entry valid, bit 1 the skid-entry valid.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StMain  = 2'b01,
    StFull  = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  main_q, main_d;
  logic [DATA_W-1:0]  skid_q, skid_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               main_v, skid_v;
  logic               in_xfer, out_xfer;

  assign main_v = state_q[0];
  assign skid_v = state_q[1];

  // With a skid entry the ready is a flop bit; without, it looks through to out_ready.
  assign in_ready  = UseSkid ? !skid_v : (!main_v || out_ready);
  assign out_valid = main_v;
  assign out_data  = main_q;
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};
  assign stall_cnt = stall_cnt_q;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      StEmpty: begin
        if (in_xfer) begin
          main_d  = in_data;
          state_d = StMain;
        end
      end
      StMain: begin
        if (in_xfer && out_xfer) begin
          main_d = in_data;
        end else if (in_xfer) begin
          skid_d  = in_data;
          state_d = StFull;
        end else if (out_xfer) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = StMain;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (flush) begin
      state_d = StEmpty;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr) begin
      stall_cnt_d = '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      main_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed and scoreboard bench for pipe_stage_hs: a skid instance (CNT_W=4) and a
// single-entry instance driven with random handshakes.
module tb_pipe_stage_hs;

  logic       clk;
  logic       rst_n;

  logic       in_valid, in_ready, out_valid, out_ready, flush, stall_clr;
  logic [7:0] in_data, out_data;
  logic [1:0] occupancy;
  logic [3:0] stall_cnt;

  logic        s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready;
  logic [7:0]  s0_in_data, s0_out_data;
  logic [1:0]  s0_occupancy;
  logic [15:0] s0_stall_cnt;

  int errors = 0;
  int checks = 0;

  pipe_stage_hs #(.DATA_W(8), .SKID(1), .CNT_W(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt),
    .stall_clr (stall_clr)
  );

  pipe_stage_hs #(.DATA_W(8), .SKID(0), .CNT_W(16)) u_dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s0_in_valid),
    .in_ready  (s0_in_ready),
    .in_data   (s0_in_data),
    .out_valid (s0_out_valid),
    .out_ready (s0_out_ready),
    .out_data  (s0_out_data),
    .flush     (1'b0),
    .occupancy (s0_occupancy),
    .stall_cnt (s0_stall_cnt),
    .stall_clr (1'b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; returns 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] seq;
    logic       exp_rdy, in_x, out_x;
    int         s0_stall;

    rst_n = 1'b0;
    in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b0; flush = 1'b0; stall_clr = 1'b0;
    s0_in_valid = 1'b1; s0_in_data = 8'hBB; s0_out_ready = 1'b0;

    // Reset held two cycles with valid input
    cyc();
    cyc();
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_occupancy", occupancy, 0);
    check_eq("rst_stall_cnt", stall_cnt, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_s0_out_valid", s0_out_valid, 0);
    rst_n = 1'b1; in_valid = 1'b0; s0_in_valid = 1'b0;
    cyc();
    check_eq("rel_out_valid", out_valid, 0);
    check_eq("rel_in_ready", in_ready, 1);

    // Streaming 0x01..0x10 with out_ready high
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      cyc();
      check_eq("stream_valid", out_valid, 1);
      check_eq("stream_data", out_data, 32'(i));
      check_eq("stream_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    cyc();
    check_eq("stream_drain_valid", out_valid, 0);
    check_eq("stream_stall_cnt", stall_cnt, 0);

    // Back-pressure: A, B, C with out_ready low
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hA1;
    cyc();
    check_eq("bp_a_data", out_data, 8'hA1);
    check_eq("bp_a_occ", occupancy, 1);
    in_data = 8'hB2;
    cyc();
    check_eq("bp_full_occ", occupancy, 2);
    check_eq("bp_full_ready", in_ready, 0);
    check_eq("bp_full_data", out_data, 8'hA1);
    in_data = 8'hC3;
    cyc();
    cyc();
    check_eq("bp_hold_occ", occupancy, 2);
    check_eq("bp_hold_data", out_data, 8'hA1);
    check_eq("bp_hold_cnt", stall_cnt, 3);
    out_ready = 1'b1;
    #1;
    check_eq("bp_ready_registered", in_ready, 0);
    cyc();
    check_eq("bp_b_data", out_data, 8'hB2);
    check_eq("bp_b_ready", in_ready, 1);
    check_eq("bp_b_occ", occupancy, 1);
    cyc();
    check_eq("bp_c_data", out_data, 8'hC3);
    check_eq("bp_c_valid", out_valid, 1);
    in_valid = 1'b0;
    cyc();
    check_eq("bp_empty_valid", out_valid, 0);
    check_eq("bp_stall_cnt", stall_cnt, 3);

    // Flush from FULL with D offered
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hE1;
    cyc();
    in_data = 8'hF2;
    cyc();
    check_eq("fl_full_occ", occupancy, 2);
    in_data = 8'hD0; flush = 1'b1;
    cyc();
    check_eq("fl_valid", out_valid, 0);
    check_eq("fl_occ", occupancy, 0);
    check_eq("fl_ready", in_ready, 1);
    check_eq("fl_stall_cnt", stall_cnt, 5);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    check_eq("fl_no_d", out_valid, 0);

    // Flush from MAIN discards a concurrent in-transfer
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h61;
    cyc();
    in_data = 8'h72; flush = 1'b1;
    cyc();
    check_eq("flm_valid", out_valid, 0);
    flush = 1'b0; in_valid = 1'b0;
    cyc();
    check_eq("flm_after_valid", out_valid, 0);
    check_eq("flm_after_occ", occupancy, 0);
    check_eq("flm_stall_cnt", stall_cnt, 6);

    // Saturation and clear
    stall_clr = 1'b1;
    cyc();
    check_eq("clr_cnt", stall_cnt, 0);
    stall_clr = 1'b0;
    in_valid = 1'b1; in_data = 8'h55;
    cyc();
    in_valid = 1'b0;
    repeat (20) cyc();
    check_eq("sat_cnt", stall_cnt, 15);
    check_eq("sat_data", out_data, 8'h55);
    stall_clr = 1'b1;
    cyc();
    check_eq("sat_clr_cnt", stall_cnt, 0);
    stall_clr = 1'b0;
    cyc();
    check_eq("sat_inc1", stall_cnt, 1);
    cyc();
    check_eq("sat_inc2", stall_cnt, 2);
    out_ready = 1'b1;
    cyc();
    check_eq("sat_drain_valid", out_valid, 0);

    // Reset mid-traffic drops entries
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11;
    cyc();
    in_data = 8'h22;
    cyc();
    check_eq("mid_occ_pre", occupancy, 2);
    rst_n = 1'b0; flush = 1'b1; stall_clr = 1'b0;
    cyc();
    check_eq("mid_rst_occ", occupancy, 0);
    check_eq("mid_rst_data", out_data, 0);
    check_eq("mid_rst_cnt", stall_cnt, 0);
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
    cyc();

    // Single-entry random handshakes against a scoreboard
    seq = 8'h00;
    s0_stall = 0;
    for (int c = 0; c < 10000; c++) begin
      s0_in_valid  = ($urandom_range(0, 3) != 0);
      s0_out_ready = ($urandom_range(0, 2) != 0);
      s0_in_data   = seq;
      #1;
      exp_rdy = (q.size() == 0) || s0_out_ready;
      check_eq("s0_in_ready", s0_in_ready, exp_rdy);
      check_eq("s0_out_valid", s0_out_valid, q.size() != 0);
      if (q.size() != 0) check_eq("s0_out_data", s0_out_data, q[0]);
      in_x  = s0_in_valid && exp_rdy;
      out_x = (q.size() != 0) && s0_out_ready;
      if ((q.size() != 0) && !s0_out_ready && s0_stall < 65535) s0_stall++;
      if (out_x) void'(q.pop_front());
      if (in_x) begin
        q.push_back(seq);
        seq = seq + 8'd1;
      end
      cyc();
    end
    check_eq("s0_stall_cnt", s0_stall_cnt, s0_stall);
    check_eq("s0_occupancy", s0_occupancy, q.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
